shift_issue_buf: RTL and testbench
==================================

SHIFT_ISSUE_BUF -- requirements
Module: shift_issue_buf

Interface
REQ-001 Parameter: DEPTH, default 2, number of queue entries; power of two, >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream shift micro-op valid.
REQ-005 Port: in_ready  output  1  queue can accept; equals "not full".
REQ-006 Port: in_funct3 / in_funct7_5  input  3 / 1  RV32 funct3 and instr[30].
REQ-007 Port: in_is_imm  input  1  1 = SLLI/SRLI/SRAI (use in_imm), 0 = register form (use in_rs2).
REQ-008 Port: in_rs1 / in_rs2  input  32 / 32  operand values.
REQ-009 Port: in_imm / in_rd  input  5 / 5  shamt immediate; destination register tag.
REQ-010 Port: sh_a / sh_b  output  32 / 32  operands to the barrel shifter; sh_b[31:5] = 0 in imm form.
REQ-011 Port: sh_op  output  2  shifter code: 00 SRL, 10 SLL, 01 SRA.
REQ-012 Port: sh_out  input  32  combinational shifter result for the current sh_a/sh_b/sh_op.
REQ-013 Port: res_valid / res_ready  output / input  1 / 1  result handshake to writeback.
REQ-014 Port: res_data / res_rd / res_illegal  output  32 / 5 / 1  result, tag, illegal-encoding flag.
REQ-015 Port (SHIFT_ISSUE_FLUSH_EN only): flush  input  1  discard all in-flight ops.

Function
REQ-016 Enqueue occurs when in_valid && in_ready; the entry stores the operands, in_rd, and the decoded sh_op/illegal bits.
REQ-017 Decode: funct3=001 with funct7_5=0 gives 10; funct3=101 with funct7_5=0 gives 00; funct3=101 with funct7_5=1 gives 01; anything else is illegal with sh_op=00.
REQ-018 sh_a/sh_b/sh_op SHALL be driven from the queue head; they are 0 when the queue is empty.
REQ-019 Head issue occurs when the queue is non-empty and the output register is empty or res_ready=1 (the output register drains the same cycle).
REQ-020 On issue, the output register captures res_data=sh_out (or 0 if illegal), res_rd, and res_illegal, and sets res_valid=1.
REQ-021 Latency: an op accepted into an empty queue with an empty output register SHALL present res_valid on the next cycle only.
REQ-022 Steady-state throughput with res_ready held high SHALL be 1 op per cycle.
REQ-023 res_valid SHALL stay high, and res_data/res_rd/res_illegal stable, until res_ready=1.
REQ-024 Simultaneous enqueue and issue when full is not allowed (in_ready=0); when not full, both SHALL occur and the count is unchanged.
REQ-025 Pointers wrap modulo DEPTH; the count occupies log2(DEPTH)+1 bits.
REQ-026 Order is strict FIFO; there is no bypass of the queue.

Reset
REQ-027 When rst_n=0 at a clock edge: the queue is emptied, pointers and count are 0, res_valid=0, and res_data/res_rd/res_illegal=0.
REQ-028 Reset asserted mid-operation SHALL drop all queued and held ops with no partial result; in_ready=1 in the first cycle after release.

Configuration
REQ-029 Macro SHIFT_ISSUE_FLUSH_EN: when defined, the flush port exists.
REQ-030 When flush=1, the queue empties and res_valid clears at the next edge; enqueue and issue in that cycle are discarded.
REQ-031 If flush and rst_n=0 coincide, reset takes precedence and the resulting state is identical.
REQ-032 When SHIFT_ISSUE_FLUSH_EN is undefined, the port is absent and behaviour is otherwise identical.

Verification
REQ-033 SLLI: rs1=0x0000_0001, imm=31, funct3=001, res_ready=1 -> next cycle res_valid=1, res_data=0x8000_0000, sh_op seen as 10.
REQ-034 SRA register form: rs1=0x8000_0000, rs2=0xFFFF_FFE4 (shamt 4), funct3=101, f7_5=1 -> res_data=0xF800_0000.
REQ-035 Backpressure: res_ready=0, push 3 ops with DEPTH=2 -> in_ready=0 after 2 queued + 1 held; release -> results return in order, none lost.
REQ-036 Illegal: funct3=001 with f7_5=1 -> res_illegal=1, res_data=0.
REQ-037 Reset with 2 ops queued and 1 held -> res_valid=0 and in_ready=1 the next cycle; no stale result ever appears.
REQ-038 With SHIFT_ISSUE_FLUSH_EN: flush while full and in_valid=1 -> queue empty, res_valid=0 next cycle, flushed op never appears.

Source files
------------

// File: rtl/shift_issue_buf.sv
// shift_issue_buf: in-order FIFO of decoded RV32 shift micro-ops feeding an
// external combinational barrel shifter, with a registered result stage.
// Optional feature macro: SHIFT_ISSUE_FLUSH_EN (adds the flush input that
// discards every queued and held op at the next clock edge).
module shift_issue_buf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SHIFT_ISSUE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7_5,
    input  logic        in_is_imm,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_imm,
    input  logic [4:0]  in_rd,
    output logic [31:0] sh_a,
    output logic [31:0] sh_b,
    output logic [1:0]  sh_op,
    input  logic [31:0] sh_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_illegal
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b01;

    // Queue storage: operands already muxed to shifter form.
    logic [31:0]   mem_a_q   [DEPTH];
    logic [31:0]   mem_a_d   [DEPTH];
    logic [31:0]   mem_b_q   [DEPTH];
    logic [31:0]   mem_b_d   [DEPTH];
    logic [1:0]    mem_op_q  [DEPTH];
    logic [1:0]    mem_op_d  [DEPTH];
    logic          mem_ill_q [DEPTH];
    logic          mem_ill_d [DEPTH];
    logic [4:0]    mem_rd_q  [DEPTH];
    logic [4:0]    mem_rd_d  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_data_q, res_data_d;
    logic [4:0]    res_rd_q, res_rd_d;
    logic          res_ill_q, res_ill_d;

    logic          flush_w;
    logic          empty;
    logic          full;
    logic          push;
    logic          issue;
    logic [1:0]    dec_op;
    logic          dec_ill;
    logic [31:0]   dec_b;

`ifdef SHIFT_ISSUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Queue status and handshake decisions.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        in_ready = !full;
        push     = in_valid && !full;
        issue    = !empty && (!res_valid_q || res_ready);
    end

    // Decode funct3/funct7[5] into shifter code and select the shift operand.
    always_comb begin
        dec_op  = OP_SRL;
        dec_ill = 1'b0;
        unique case ({in_funct3, in_funct7_5})
            4'b001_0: dec_op = OP_SLL;
            4'b101_0: dec_op = OP_SRL;
            4'b101_1: dec_op = OP_SRA;
            default:  dec_ill = 1'b1;
        endcase
        dec_b = in_is_imm ? {27'd0, in_imm} : in_rs2;
    end

    // Present the queue head to the barrel shifter; zero when empty.
    always_comb begin
        sh_a  = '0;
        sh_b  = '0;
        sh_op = '0;
        if (!empty) begin
            sh_a  = mem_a_q[rd_ptr_q];
            sh_b  = mem_b_q[rd_ptr_q];
            sh_op = mem_op_q[rd_ptr_q];
        end
    end

    // Next-state for queue, pointers, count and the result register.
    always_comb begin
        mem_a_d     = mem_a_q;
        mem_b_d     = mem_b_q;
        mem_op_d    = mem_op_q;
        mem_ill_d   = mem_ill_q;
        mem_rd_d    = mem_rd_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_ill_d   = res_ill_q;

        if (push) begin
            mem_a_d[wr_ptr_q]   = in_rs1;
            mem_b_d[wr_ptr_q]   = dec_b;
            mem_op_d[wr_ptr_q]  = dec_op;
            mem_ill_d[wr_ptr_q] = dec_ill;
            mem_rd_d[wr_ptr_q]  = in_rd;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end

        if (issue) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            res_valid_d = 1'b1;
            res_data_d  = mem_ill_q[rd_ptr_q] ? '0 : sh_out;
            res_rd_d    = mem_rd_q[rd_ptr_q];
            res_ill_d   = mem_ill_q[rd_ptr_q];
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end

        unique case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush overrides everything decided above; payload regs keep their
        // values since res_valid alone qualifies them.
        if (flush_w) begin
            mem_a_d     = mem_a_q;
            mem_b_d     = mem_b_q;
            mem_op_d    = mem_op_q;
            mem_ill_d   = mem_ill_q;
            mem_rd_d    = mem_rd_q;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            res_valid_d = 1'b0;
            res_data_d  = res_data_q;
            res_rd_d    = res_rd_q;
            res_ill_d   = res_ill_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_a_q     <= '{default: '0};
            mem_b_q     <= '{default: '0};
            mem_op_q    <= '{default: '0};
            mem_ill_q   <= '{default: '0};
            mem_rd_q    <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_ill_q   <= 1'b0;
        end else begin
            mem_a_q     <= mem_a_d;
            mem_b_q     <= mem_b_d;
            mem_op_q    <= mem_op_d;
            mem_ill_q   <= mem_ill_d;
            mem_rd_q    <= mem_rd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_ill_q   <= res_ill_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_illegal = res_ill_q;

endmodule

// File: tb/tb_shift_issue_buf.sv
// Testbench for shift_issue_buf: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_shift_issue_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_r;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic        in_is_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_imm;
    logic [4:0]  in_rd;
    logic [31:0] sh_a;
    logic [31:0] sh_b;
    logic [1:0]  sh_op;
    logic [31:0] sh_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_issue_buf #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SHIFT_ISSUE_FLUSH_EN
        .flush       (flush_r),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_funct7_5 (in_funct7_5),
        .in_is_imm   (in_is_imm),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_rd       (in_rd),
        .sh_a        (sh_a),
        .sh_b        (sh_b),
        .sh_op       (sh_op),
        .sh_out      (sh_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_illegal (res_illegal)
    );

    // External barrel shifter.
    always_comb begin
        case (sh_op)
            2'b10:   sh_out = sh_a << sh_b[4:0];
            2'b00:   sh_out = sh_a >> sh_b[4:0];
            2'b01:   sh_out = $unsigned($signed(sh_a) >>> sh_b[4:0]);
            default: sh_out = '0;
        endcase
    end

    // Reference model: queue of raw instructions plus one result slot.
    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  imm;
        logic [4:0]  rd;
        logic        is_imm;
        logic [2:0]  f3;
        logic        f75;
    } ent_t;

    ent_t        mq[$];
    logic        m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    logic        m_ill;
    logic        m_zero;

    function automatic logic [4:0] m_shamt(input ent_t e);
        return e.is_imm ? e.imm : e.rs2[4:0];
    endfunction

    function automatic logic m_illegal(input ent_t e);
        return !((e.f3 == 3'd1 && !e.f75) || (e.f3 == 3'd5));
    endfunction

    function automatic logic [1:0] m_opcode(input ent_t e);
        if (e.f3 == 3'd1 && !e.f75) return 2'b10;
        if (e.f3 == 3'd5 && e.f75)  return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_result(input ent_t e);
        logic [4:0]  s;
        logic signed [31:0] sv;
        s  = m_shamt(e);
        sv = e.rs1;
        if (m_illegal(e))               return 32'd0;
        if (e.f3 == 3'd1)               return e.rs1 << s;
        if (e.f75)                      return $unsigned(sv >>> s);
        return e.rs1 >> s;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model with the currently driven inputs, cross one rising
    // edge, then compare every DUT output at the following falling edge.
    task automatic tick();
        ent_t e;
        bit do_push;
        bit do_issue;
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_rd    = '0;
            m_ill   = 1'b0;
            m_zero  = 1'b1;
        end else if (flush_r) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            do_push  = in_valid && (mq.size() < DEPTH);
            do_issue = (mq.size() > 0) && (!m_valid || res_ready);
            if (do_issue) begin
                e       = mq.pop_front();
                m_valid = 1'b1;
                m_data  = m_result(e);
                m_rd    = e.rd;
                m_ill   = m_illegal(e);
                m_zero  = 1'b0;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
            if (do_push) begin
                e.rs1 = in_rs1; e.rs2 = in_rs2; e.imm = in_imm; e.rd = in_rd;
                e.is_imm = in_is_imm; e.f3 = in_funct3; e.f75 = in_funct7_5;
                mq.push_back(e);
            end
        end
        @(negedge clk);
        chk_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk_eq("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid || m_zero) begin
            chk_eq("res_data", res_data, m_data);
            chk_eq("res_rd", 32'(res_rd), 32'(m_rd));
            chk_eq("res_illegal", 32'(res_illegal), 32'(m_ill));
        end
        if (mq.size() > 0) begin
            chk_eq("sh_a", sh_a, mq[0].rs1);
            chk_eq("sh_b", sh_b, mq[0].is_imm ? {27'd0, mq[0].imm} : mq[0].rs2);
            chk_eq("sh_op", 32'(sh_op), 32'(m_opcode(mq[0])));
        end else begin
            chk_eq("sh_a_empty", sh_a, 32'd0);
            chk_eq("sh_b_empty", sh_b, 32'd0);
            chk_eq("sh_op_empty", 32'(sh_op), 32'd0);
        end
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic f75, input logic is_imm,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [4:0] imm, input logic [4:0] rd);
        in_valid = 1'b1; in_funct3 = f3; in_funct7_5 = f75; in_is_imm = is_imm;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] f3;
        rst_n = 1'b0; flush_r = 1'b0; res_ready = 1'b1;
        drive_op(3'd0, 1'b0, 1'b0, '0, '0, '0, '0);
        in_valid = 1'b0;
        m_valid = 1'b0; m_data = '0; m_rd = '0; m_ill = 1'b0; m_zero = 1'b1;
        @(negedge clk);

        // Reset state.
        tick();
        tick();
        chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
        chk_eq("rst_res_data", res_data, 32'd0);
        rst_n = 1'b1;

        // SLLI by 31.
        drive_op(3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd31, 5'd7);
        tick();
        chk_eq("slli_sh_op", 32'(sh_op), 32'b10);
        drive_idle();
        tick();
        chk_eq("slli_valid", 32'(res_valid), 32'd1);
        chk_eq("slli_data", res_data, 32'h8000_0000);
        tick();

        // SRA register form, shamt 4.
        drive_op(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 5'd9);
        tick();
        drive_idle();
        tick();
        chk_eq("sra_data", res_data, 32'hF800_0000);

        // Illegal encoding.
        drive_op(3'b001, 1'b1, 1'b1, 32'h1234_5678, 32'h0, 5'd3, 5'd4);
        tick();
        drive_idle();
        tick();
        chk_eq("ill_flag", 32'(res_illegal), 32'd1);
        chk_eq("ill_data", res_data, 32'd0);
        tick();

        // Backpressure: 2 queued + 1 held, then release in order.
        res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_op(3'b101, 1'b0, 1'b1, 32'h0000_0100 * i, 32'h0, 5'(i), 5'(i));
            tick();
        end
        chk_eq("bp_in_ready", 32'(in_ready), 32'd0);
        drive_op(3'b001, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd1, 5'd30);
        tick();
        chk_eq("bp_hold_rd", 32'(res_rd), 32'd1);
        drive_idle();
        res_ready = 1'b1;
        tick();
        chk_eq("bp_rd2", 32'(res_rd), 32'd2);
        tick();
        chk_eq("bp_rd3", 32'(res_rd), 32'd3);
        tick();
        tick();

        // Reset with 2 queued and 1 held.
        res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_op(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'(i), 5'(10 + i));
            tick();
        end
        drive_idle();
        rst_n = 1'b0;
        tick();
        chk_eq("rst_mid_valid", 32'(res_valid), 32'd0);
        chk_eq("rst_mid_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
        tick();

`ifdef SHIFT_ISSUE_FLUSH_EN
        // Flush while full with a new op offered.
        res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_op(3'b101, 1'b0, 1'b1, 32'hF0, 32'h0, 5'(i), 5'(20 + i));
            tick();
        end
        drive_op(3'b101, 1'b0, 1'b1, 32'hF0, 32'h0, 5'd1, 5'd31);
        flush_r = 1'b1;
        tick();
        flush_r = 1'b0;
        drive_idle();
        chk_eq("flush_valid", 32'(res_valid), 32'd0);
        chk_eq("flush_ready", 32'(in_ready), 32'd1);
        res_ready = 1'b1;
        tick();
        chk_eq("flush_no_stale", 32'(res_valid), 32'd0);
`endif

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       f3 = 3'b001;
                1, 2:    f3 = 3'b101;
                default: f3 = 3'($urandom);
            endcase
            drive_op(f3, 1'($urandom), 1'($urandom), $urandom, $urandom,
                     5'($urandom), 5'($urandom));
            in_valid  = ($urandom_range(0, 9) < 7);
            res_ready = ($urandom_range(0, 9) < 6);
            rst_n     = ($urandom_range(0, 99) != 0);
`ifdef SHIFT_ISSUE_FLUSH_EN
            flush_r   = ($urandom_range(0, 49) == 0);
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
